// File: rtl/tile_render_pkg.sv
// -----------------------------------------------------------------------------
// tile_render_pkg
// Shared definitions for the tile frame renderer:
//   - state_e       : frame FSM states
//   - DEF_*_COLOR   : default 9-bit palette entries
//   - idx_w()       : index width for a count of items (never below 1)
//   - tile_arith_w(): width of the signed tile-edge arithmetic
// -----------------------------------------------------------------------------
package tile_render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_DIVIDER   = 3'd2,
        ST_TILE_SEL  = 3'd3,
        ST_TILE_DRAW = 3'd4,
        ST_HITBOX    = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    localparam logic [8:0] DEF_BG_COLOR     = 9'h1FF;
    localparam logic [8:0] DEF_LINE_COLOR   = 9'h000;
    localparam logic [8:0] DEF_TILE_COLOR   = 9'h000;
    localparam logic [8:0] DEF_HIT_COLOR    = 9'h124;
    localparam logic [8:0] DEF_HITBOX_COLOR = 9'h038;

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int idx_w(input int n);
        int w;
        if (n <= 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    // Signed tile-edge width: spans every row offset plus sign and headroom,
    // so top/bottom never wrap.
    function automatic int tile_arith_w(input int tile_h, input int num_rows);
        return $clog2(tile_h * (num_rows + 32'sd2)) + 32'sd2;
    endfunction

endpackage

// File: rtl/tile_frame_renderer_rect_scanner.sv
// -----------------------------------------------------------------------------
// rect_scanner
// Row-major walker over an inclusive rectangle (x0,y0)..(x1,y1).
//   clk, reset      : clock, synchronous active-high reset
//   load            : capture corners, position jumps to (x0,y0)
//   step            : advance one pixel (ignored while load is high)
//   x0,y0,x1,y1     : rectangle corners, sampled on load
//   x, y            : current pixel (registered)
//   last            : current pixel is the final one of the rectangle
// -----------------------------------------------------------------------------
module rect_scanner
    import tile_render_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] x1_q, x1_d;
    logic [YW-1:0] y1_q, y1_d;

    // Next position: load wins, otherwise wrap to the left edge at row end.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        x0_d = x0_q;
        x1_d = x1_q;
        y1_d = y1_q;
        if (load) begin
            x_d  = x0;
            y_d  = y0;
            x0_d = x0;
            x1_d = x1;
            y1_d = y1;
        end else if (step) begin
            if (x_q == x1_q) begin
                x_d = x0_q;
                y_d = y_q + YW'(1'b1);
            end else begin
                x_d = x_q + XW'(1'b1);
            end
        end else begin
            x_d = x_q;
        end
    end

    // Position and bound registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q  <= {XW{1'b0}};
            y_q  <= {YW{1'b0}};
            x0_q <= {XW{1'b0}};
            x1_q <= {XW{1'b0}};
            y1_q <= {YW{1'b0}};
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/tile_frame_renderer.sv
// -----------------------------------------------------------------------------
// tile_frame_renderer
// Draws one full piano-tiles frame per start as a valid/ready pixel stream:
// background clear, lane dividers, tile grid (hit rows shaded), hitbox line.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a frame (only honoured in IDLE)
//   keys                : tile map, row r at [r*NUM_LANES +: NUM_LANES], row 0 bottom
//   yoffset             : y of the top edge of row 0
//   num_hit             : rows below this index use HIT_COLOR
//   px_x, px_y, px_color: pixel write, held stable while stalled
//   px_valid, px_ready  : pixel handshake
//   busy                : frame in progress (through the done cycle)
//   done                : one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module tile_frame_renderer
    import tile_render_pkg::*;
#(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int NUM_LANES = 4,
    parameter int NUM_ROWS = 4,
    parameter int TILE_H = 30,
    parameter int HITBOX_Y = 100,
    parameter int COLOR_W = 9,
    parameter logic [COLOR_W-1:0] BG_COLOR     = COLOR_W'(DEF_BG_COLOR),
    parameter logic [COLOR_W-1:0] LINE_COLOR   = COLOR_W'(DEF_LINE_COLOR),
    parameter logic [COLOR_W-1:0] TILE_COLOR   = COLOR_W'(DEF_TILE_COLOR),
    parameter logic [COLOR_W-1:0] HIT_COLOR    = COLOR_W'(DEF_HIT_COLOR),
    parameter logic [COLOR_W-1:0] HITBOX_COLOR = COLOR_W'(DEF_HITBOX_COLOR)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [(NUM_ROWS+1)*NUM_LANES-1:0]     keys,
    input  logic [$clog2(SCREEN_H)-1:0]           yoffset,
    input  logic [$clog2(NUM_ROWS+2)-1:0]         num_hit,
    output logic [$clog2(SCREEN_W)-1:0]           px_x,
    output logic [$clog2(SCREEN_H)-1:0]           px_y,
    output logic [COLOR_W-1:0]                    px_color,
    output logic                                  px_valid,
    input  logic                                  px_ready,
    output logic                                  busy,
    output logic                                  done
);

    localparam int XW  = $clog2(SCREEN_W);
    localparam int YW  = $clog2(SCREEN_H);
    localparam int RW  = $clog2(NUM_ROWS + 2);
    localparam int LNW = idx_w(NUM_LANES);
    localparam int KW  = (NUM_ROWS + 1) * NUM_LANES;
    localparam int SW  = tile_arith_w(TILE_H, NUM_ROWS);
    localparam int LW  = SCREEN_W / NUM_LANES;

    state_e               state_q, state_d;
    logic [KW-1:0]        keys_q, keys_d;
    logic [YW-1:0]        yoff_q, yoff_d;
    logic [RW-1:0]        nhit_q, nhit_d;
    logic [RW-1:0]        row_q, row_d;
    logic [LNW-1:0]       lane_q, lane_d;
    logic [XW-1:0]        div_x_q, div_x_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 fire_s;
    logic                 ld_s, step_s;
    logic [XW-1:0]        ld_x0_s, ld_x1_s;
    logic [YW-1:0]        ld_y0_s, ld_y1_s;
    logic [XW-1:0]        scan_x_s;
    logic [YW-1:0]        scan_y_s;
    logic                 scan_last_s;

    int                   cand_idx_s;
    logic                 cand_bit_s;
    logic                 cand_last_lane_s;
    logic                 cand_end_s;
    logic [COLOR_W-1:0]   cand_color_s;
    logic signed [SW-1:0] yoff_ext_s, row_off_s, top_s, bot_s;
    logic                 tile_vis_s;
    logic [YW-1:0]        tile_y0_s, tile_y1_s;
    logic [XW-1:0]        tile_x0_s, tile_x1_s;

    rect_scanner #(
        .XW (XW),
        .YW (YW)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .load  (ld_s),
        .step  (step_s),
        .x0    (ld_x0_s),
        .y0    (ld_y0_s),
        .x1    (ld_x1_s),
        .y1    (ld_y1_s),
        .x     (scan_x_s),
        .y     (scan_y_s),
        .last  (scan_last_s)
    );

    assign fire_s = valid_q && px_ready;

    // Geometry of the current (row, lane) candidate, clipped to the screen.
    always_comb begin
        cand_idx_s       = int'(row_q) * NUM_LANES + int'(lane_q);
        cand_bit_s       = |(keys_q & (KW'(1'b1) << cand_idx_s));
        cand_last_lane_s = (lane_q == LNW'(NUM_LANES - 1));
        cand_end_s       = (row_q == RW'(NUM_ROWS + 1));
        cand_color_s     = (row_q < nhit_q) ? HIT_COLOR : TILE_COLOR;
        yoff_ext_s       = SW'(yoff_q);
        row_off_s        = SW'(int'(row_q) * TILE_H);
        top_s            = yoff_ext_s - row_off_s;
        bot_s            = top_s + SW'(TILE_H - 1);
        // Visible unless entirely above row 0 of the screen or below the last row.
        tile_vis_s       = !bot_s[SW-1] && !(top_s > SW'(SCREEN_H - 1));
        tile_y0_s        = top_s[SW-1] ? {YW{1'b0}} : top_s[YW-1:0];
        tile_y1_s        = (bot_s > SW'(SCREEN_H - 1)) ? YW'(SCREEN_H - 1) : bot_s[YW-1:0];
        tile_x0_s        = XW'(int'(lane_q) * LW);
        tile_x1_s        = XW'(int'(lane_q) * LW + LW - 1);
    end

    // Frame sequencing: picks the next layer/rectangle and drives the scanner.
    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        yoff_d  = yoff_q;
        nhit_d  = nhit_q;
        row_d   = row_q;
        lane_d  = lane_q;
        div_x_d = div_x_q;
        color_d = color_q;
        ld_s    = 1'b0;
        step_s  = 1'b0;
        ld_x0_s = {XW{1'b0}};
        ld_y0_s = {YW{1'b0}};
        ld_x1_s = {XW{1'b0}};
        ld_y1_s = {YW{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    keys_d  = keys;
                    yoff_d  = yoffset;
                    nhit_d  = num_hit;
                    row_d   = {RW{1'b0}};
                    lane_d  = {LNW{1'b0}};
                    color_d = BG_COLOR;
                    ld_s    = 1'b1;
                    ld_x1_s = XW'(SCREEN_W - 1);
                    ld_y1_s = YW'(SCREEN_H - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CLEAR: begin
                if (fire_s && scan_last_s) begin
                    if (NUM_LANES > 1) begin
                        state_d = ST_DIVIDER;
                        div_x_d = XW'(LW);
                        color_d = LINE_COLOR;
                        ld_s    = 1'b1;
                        ld_x0_s = XW'(LW);
                        ld_x1_s = XW'(LW);
                        ld_y1_s = YW'(SCREEN_H - 1);
                    end else begin
                        state_d = ST_TILE_SEL;
                    end
                end else begin
                    step_s = fire_s;
                end
            end

            ST_DIVIDER: begin
                if (fire_s && scan_last_s) begin
                    if (div_x_q == XW'(SCREEN_W - LW)) begin
                        state_d = ST_TILE_SEL;
                    end else begin
                        div_x_d = div_x_q + XW'(LW);
                        ld_s    = 1'b1;
                        ld_x0_s = div_x_d;
                        ld_x1_s = div_x_d;
                        ld_y1_s = YW'(SCREEN_H - 1);
                    end
                end else begin
                    step_s = fire_s;
                end
            end

            ST_TILE_SEL: begin
                if (cand_end_s) begin
                    state_d = ST_HITBOX;
                    color_d = HITBOX_COLOR;
                    ld_s    = 1'b1;
                    ld_y0_s = YW'(HITBOX_Y);
                    ld_x1_s = XW'(SCREEN_W - 1);
                    ld_y1_s = YW'(HITBOX_Y);
                end else begin
                    // Candidate pointer moves on whether or not this one draws,
                    // so TILE_DRAW returns to the following candidate.
                    if (cand_last_lane_s) begin
                        lane_d = {LNW{1'b0}};
                        row_d  = row_q + RW'(1'b1);
                    end else begin
                        lane_d = lane_q + LNW'(1'b1);
                    end
                    if (cand_bit_s && tile_vis_s) begin
                        state_d = ST_TILE_DRAW;
                        color_d = cand_color_s;
                        ld_s    = 1'b1;
                        ld_x0_s = tile_x0_s;
                        ld_y0_s = tile_y0_s;
                        ld_x1_s = tile_x1_s;
                        ld_y1_s = tile_y1_s;
                    end else begin
                        state_d = ST_TILE_SEL;
                    end
                end
            end

            ST_TILE_DRAW: begin
                if (fire_s && scan_last_s) begin
                    state_d = ST_TILE_SEL;
                end else begin
                    step_s = fire_s;
                end
            end

            ST_HITBOX: begin
                if (fire_s && scan_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    step_s = fire_s;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_CLEAR) || (state_d == ST_DIVIDER) ||
                  (state_d == ST_TILE_DRAW) || (state_d == ST_HITBOX);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // FSM state, latched frame inputs and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            keys_q  <= {KW{1'b0}};
            yoff_q  <= {YW{1'b0}};
            nhit_q  <= {RW{1'b0}};
            row_q   <= {RW{1'b0}};
            lane_q  <= {LNW{1'b0}};
            div_x_q <= {XW{1'b0}};
            color_q <= {COLOR_W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            yoff_q  <= yoff_d;
            nhit_q  <= nhit_d;
            row_q   <= row_d;
            lane_q  <= lane_d;
            div_x_q <= div_x_d;
            color_q <= color_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign px_x     = scan_x_s;
    assign px_y     = scan_y_s;
    assign px_color = color_q;
    assign px_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tile_frame_renderer.sv
// -----------------------------------------------------------------------------
// tb_tile_frame_renderer
// Directed frame scenarios with randomized backpressure and random tile bits.
// Expected pixel streams come from a loop-level model of the frame layers.
// -----------------------------------------------------------------------------
module tb_tile_frame_renderer;

    typedef logic [23:0] pix_t;   // {x[7:0], y[6:0], color[8:0]}

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] keys;
    logic [6:0]  yoffset;
    logic [2:0]  num_hit;
    logic [7:0]  px_x;
    logic [6:0]  px_y;
    logic [8:0]  px_color;
    logic        px_valid;
    logic        px_ready;
    logic        busy;
    logic        done;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;
    logic bp_en       = 1'b0;

    always #5 clk = ~clk;

    tile_frame_renderer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .keys     (keys),
        .yoffset  (yoffset),
        .num_hit  (num_hit),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_color (px_color),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .busy     (busy),
        .done     (done)
    );

    function automatic pix_t pk(input int x, input int y, input int c);
        return {x[7:0], y[6:0], c[8:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: layers drawn in painter's order from plain loops.
    task automatic build_exp(input logic [19:0] k, input int yoff, input int nh);
        int top, bot, ys, ye;
        exp_q.delete();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back(pk(x, y, 'h1FF));
        for (int d = 1; d < 4; d++)
            for (int y = 0; y < 120; y++)
                exp_q.push_back(pk(d * 40, y, 'h000));
        for (int r = 0; r < 5; r++) begin
            for (int l = 0; l < 4; l++) begin
                if (k[r*4+l]) begin
                    top = yoff - r * 30;
                    bot = top + 29;
                    if (bot >= 0 && top <= 119) begin
                        ys = (top < 0) ? 0 : top;
                        ye = (bot > 119) ? 119 : bot;
                        for (int y = ys; y <= ye; y++)
                            for (int x = l * 40; x < l * 40 + 40; x++)
                                exp_q.push_back(pk(x, y, (r < nh) ? 'h124 : 'h000));
                    end
                end
            end
        end
        for (int x = 0; x < 160; x++)
            exp_q.push_back(pk(x, 100, 'h038));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [19:0] k, input logic [6:0] yo, input logic [2:0] nh);
        got_q.delete();
        @(posedge clk);
        #1;
        keys    = k;
        yoffset = yo;
        num_hit = nh;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", px_valid, 1);
        check("first_pixel", pk(px_x, px_y, px_color), pk(0, 0, 'h1FF));
        check("first_busy", busy, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1);
        tick();
        tick();
    endtask

    task automatic compare_frame(input string tag);
        int first_bad;
        int n;
        first_bad = -1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                first_bad = i;
                break;
            end
        end
        if (first_bad >= 0) begin
            $display("  %s first difference at transfer %0d", tag, first_bad);
            check({tag, "_seq"}, got_q[first_bad], exp_q[first_bad]);
        end else if (n > 0) begin
            check({tag, "_seq_tail"}, got_q[n-1], exp_q[n-1]);
        end else begin
            check({tag, "_nonempty"}, n, exp_q.size());
        end
    endtask

    // Ready driver: random 50% while enabled, focused on the frame's ends.
    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en && (got_q.size() < 3000 || got_q.size() > 18500))
                px_ready = 1'($urandom_range(0, 1));
            else
                px_ready = 1'b1;
        end
    end

    // Monitor: records transfers, counts done pulses, checks stall stability.
    initial begin
        logic stall_prev;
        pix_t held;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold", {px_valid, pk(px_x, px_y, px_color)}, {1'b1, held});
                if (px_valid && px_ready)
                    got_q.push_back(pk(px_x, px_y, px_color));
                if (done)
                    done_cnt++;
                stall_prev = px_valid && !px_ready;
                held = pk(px_x, px_y, px_color);
            end
        end
    end

    initial begin
        int   dc0, c40, c80, c120, nx, bad_col;
        int   t;
        logic [19:0] k;
        logic [31:0] r;

        reset   = 1'b1;
        start   = 1'b0;
        keys    = 20'h0;
        yoffset = 7'd0;
        num_hit = 3'd0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_valid", px_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pixel", pk(px_x, px_y, px_color), 0);

        // Reset mid-frame aborts without done.
        start_frame(20'h0, 7'd0, 3'd0);
        repeat (50) tick();
        dc0 = done_cnt;
        reset = 1'b1;
        tick();
        check("abort_valid", px_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pixel", pk(px_x, px_y, px_color), 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("abort_idle_valid", px_valid, 0);
        check("abort_idle_busy", busy, 0);
        check("abort_no_done", done_cnt, dc0);

        // Empty frame, always ready.
        build_exp(20'h0, 0, 0);
        dc0 = done_cnt;
        start_frame(20'h0, 7'd0, 3'd0);
        wait_done(25000, "empty_done_seen");
        compare_frame("empty");
        check("empty_total", got_q.size(), 19720);
        if (got_q.size() > 0)
            check("empty_last", got_q[got_q.size()-1], pk(159, 100, 'h038));
        c40 = 0; c80 = 0; c120 = 0;
        foreach (got_q[i]) begin
            if (got_q[i] == pk(40, got_q[i][15:9], 'h000))  c40++;
            if (got_q[i] == pk(80, got_q[i][15:9], 'h000))  c80++;
            if (got_q[i] == pk(120, got_q[i][15:9], 'h000)) c120++;
        end
        check("div_col40", c40, 120);
        check("div_col80", c80, 120);
        check("div_col120", c120, 120);
        check("empty_done_once", done_cnt - dc0, 1);

        // Clipping under random backpressure.
        k = 20'h10004;
        build_exp(k, 110, 0);
        bp_en = 1'b1;
        start_frame(k, 7'd110, 3'd0);
        wait_done(70000, "clip_done_seen");
        bp_en = 1'b0;
        compare_frame("clip");
        t = 19560;
        if (got_q.size() >= t + 1200) begin
            check("clip_r0_first", got_q[t], pk(80, 110, 'h000));
            check("clip_r0_last", got_q[t+399], pk(119, 119, 'h000));
            check("clip_r4_first", got_q[t+400], pk(0, 0, 'h000));
            check("clip_r4_last", got_q[t+1199], pk(39, 19, 'h000));
        end else begin
            check("clip_short", got_q.size(), t + 1200);
        end

        // Hit shading with random extra tiles, start pulses and input churn.
        r = $urandom;
        k = 20'h00222;
        k[14] = r[0];
        k[15] = r[1];
        k[18] = r[2];
        k[19] = r[3];
        build_exp(k, 90, 2);
        dc0 = done_cnt;
        start_frame(k, 7'd90, 3'd2);
        repeat (100) tick();
        start   = 1'b1;
        keys    = 20'($urandom);
        yoffset = 7'($urandom_range(0, 127));
        num_hit = 3'($urandom_range(0, 5));
        tick();
        start = 1'b0;
        repeat (19500) tick();
        check("hit_busy_mid", busy, 1);
        start   = 1'b1;
        keys    = 20'($urandom);
        tick();
        start = 1'b0;
        wait_done(10000, "hit_done_seen");
        compare_frame("hit");
        t = 19560;
        if (got_q.size() >= t + 3600) begin
            check("hit_r0_first", got_q[t], pk(40, 90, 'h124));
            check("hit_r1_first", got_q[t+1200], pk(40, 60, 'h124));
            check("hit_r2_first", got_q[t+2400], pk(40, 30, 'h000));
            check("hit_r2_last", got_q[t+3599], pk(79, 59, 'h000));
        end else begin
            check("hit_short", got_q.size(), t + 3600);
        end
        nx = 0;
        bad_col = 0;
        for (int i = t; i < got_q.size() - 160; i++) begin
            if (got_q[i][23:16] >= 8'd40 && got_q[i][23:16] <= 8'd79) begin
                nx++;
                if (got_q[i][8:0] !== ((got_q[i][15:9] >= 7'd60) ? 9'h124 : 9'h000))
                    bad_col++;
            end
        end
        check("hit_lane1_pixels", nx, 3600);
        check("hit_lane1_shading", bad_col, 0);
        repeat (10) tick();
        check("hit_single_frame", done_cnt - dc0, 1);
        check("hit_idle_busy", busy, 0);
        check("hit_idle_valid", px_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
